// File: rtl/dcache_refill_unit.sv
// Data-cache miss-repair engine: fetches a 1024-bit line as 32-bit beats and installs it as a full-mask fill.
// Optional critical-word-first burst ordering is enabled by defining DCACHE_REFILL_CWF_EN.
module dcache_refill_unit #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 1024,
    parameter int BEAT_W = 32,
    parameter int OFF_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_repair_request,
    input  logic                  write_repair_request,
    input  logic [ADDR_W-1:0]     missed_addr,
    output logic                  repair_resolved,
    output logic                  fill_valid,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [LINE_W-1:0]     fill_data,
    output logic [LINE_W/8-1:0]   fill_wmask,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [BEAT_W-1:0]     mem_rsp_data,
    output logic                  busy
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = OFF_W - 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_RECV    = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_RESOLVE = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]              state;
    logic [ADDR_W-OFF_W-1:0] base_tag;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        slot;
    logic [LINE_W-1:0]       line_buf;
    logic [ADDR_W-1:0]       fill_addr_q;
    logic [ADDR_W-1:0]       req_addr;
    logic                    miss_seen;

`ifdef DCACHE_REFILL_CWF_EN
    logic [CNT_W-1:0] w0;
    logic [1:0]       unused_addr_bits;

    // Memory returns the missed word first; the 5-bit add wraps the slot modulo BEATS.
    assign slot             = cnt + w0;
    assign req_addr         = {base_tag, w0, 2'b00};
    assign unused_addr_bits = missed_addr[1:0];
`else
    logic [OFF_W-1:0] unused_addr_bits;

    assign slot             = cnt;
    assign req_addr         = {base_tag, {OFF_W{1'b0}}};
    assign unused_addr_bits = missed_addr[OFF_W-1:0];
`endif

    assign miss_seen       = read_repair_request | write_repair_request;
    assign busy            = (state != S_IDLE);
    assign mem_req_valid   = (state == S_REQ);
    assign mem_req_addr    = mem_req_valid ? req_addr : '0;
    assign fill_valid      = (state == S_FILL);
    assign fill_wmask      = {(LINE_W/8){fill_valid}};
    assign repair_resolved = (state == S_RESOLVE);
    assign fill_data       = line_buf;
    assign fill_addr       = fill_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line buffer is a wide register, not a RAM, so it is cleared in reset to
            // guarantee an aborted burst can never leak partial beats into a later fill.
            state       <= S_IDLE;
            base_tag    <= '0;
            cnt         <= '0;
            line_buf    <= '0;
            fill_addr_q <= '0;
`ifdef DCACHE_REFILL_CWF_EN
            w0          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_seen) begin
                        base_tag    <= missed_addr[ADDR_W-1:OFF_W];
`ifdef DCACHE_REFILL_CWF_EN
                        w0          <= missed_addr[OFF_W-1:2];
`endif
                        line_buf    <= '0;
                        fill_addr_q <= '0;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (mem_rsp_valid) begin
                        line_buf[slot*BEAT_W +: BEAT_W] <= mem_rsp_data;
                        if (cnt == CNT_W'(BEATS-1)) begin
                            fill_addr_q <= {base_tag, {OFF_W{1'b0}}};
                            state       <= S_FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FILL:    state <= S_RESOLVE;
                S_RESOLVE: state <= S_GAP;
                // Requests are ignored here so the controller can drop its level.
                S_GAP:     state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for dcache_refill_unit: stimulus pushes expected lines/addresses, a monitor pops and compares.
// Honours DCACHE_REFILL_CWF_EN for the expected beat-to-slot placement.
module tb_dcache_refill_unit;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 1024;
    localparam int BEAT_W = 32;
    localparam int OFF_W  = 7;
    localparam int BEATS  = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                read_repair_request;
    logic                write_repair_request;
    logic [ADDR_W-1:0]   missed_addr;
    logic                repair_resolved;
    logic                fill_valid;
    logic [ADDR_W-1:0]   fill_addr;
    logic [LINE_W-1:0]   fill_data;
    logic [LINE_W/8-1:0] fill_wmask;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_rsp_valid;
    logic [BEAT_W-1:0]   mem_rsp_data;
    logic                busy;

    always #5 clk = ~clk;

    dcache_refill_unit #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .read_repair_request(read_repair_request),
        .write_repair_request(write_repair_request),
        .missed_addr(missed_addr),
        .repair_resolved(repair_resolved),
        .fill_valid(fill_valid), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_wmask(fill_wmask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues shared between stimulus, memory responder and monitor.
    logic [31:0]     beat_q[$];
    int              dly_q[$];
    int              gap_q[$];
    logic [31:0]     req_q[$];
    logic [31:0]     fa_q[$];
    logic [1023:0]   exp_line_q[$];
    bit              rsp_abort = 1'b0;
    int              cur_beat  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        logic [31:0] a;
        logic [31:0] e;
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < BEATS; i++) begin
                a = act[i*32 +: 32];
                e = exp[i*32 +: 32];
                if (a !== e) begin
                    $display("FAIL %s: word %0d got %08h, expected %08h", name, i, a, e);
                    break;
                end
            end
        end
    endtask

    task automatic fail_msg(input string msg);
        n_vec++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    // Reference model: the line is the beat sequence scattered into slots by the burst order.
    task automatic prep_txn(input logic [31:0] addr, input int dly, input int gap, input bit ramp);
        logic [1023:0] line;
        logic [31:0]   beat;
        logic [31:0]   base;
        int            w0;
        int            slot;
        line = '0;
        base = addr & 32'hFFFF_FF80;
        w0   = int'(addr[6:2]);
        for (int k = 0; k < BEATS; k++) begin
            beat = ramp ? 32'(k) * 32'h0101_0101 : $urandom;
            beat_q.push_back(beat);
`ifdef DCACHE_REFILL_CWF_EN
            slot = (w0 + k) % BEATS;
`else
            slot = k;
`endif
            line[slot*32 +: 32] = beat;
        end
`ifdef DCACHE_REFILL_CWF_EN
        req_q.push_back(base + 32'(4 * w0));
`else
        req_q.push_back(base);
`endif
        fa_q.push_back(base);
        exp_line_q.push_back(line);
        dly_q.push_back(dly);
        gap_q.push_back(gap);
    endtask

    task automatic wait_resolved(output int latency);
        int  start;
        bit  seen;
        start = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (repair_resolved) begin
                seen = 1'b1;
                break;
            end
        end
        latency = cyc - start + 1;
        if (!seen) fail_msg("resolved_timeout: no repair_resolved within 3000 cycles");
    endtask

    task automatic run_txn(input logic [31:0] addr, input bit rd, input bit wr, input int dly,
                           input int gap, input bit ramp, input bit hold, output int latency);
        prep_txn(addr, dly, gap, ramp);
        @(negedge clk);
        missed_addr          = addr;
        read_repair_request  = rd;
        write_repair_request = wr;
        wait_resolved(latency);
        if (hold) @(negedge clk);
        read_repair_request  = 1'b0;
        write_repair_request = 1'b0;
        missed_addr          = $urandom;
        repeat (2) @(negedge clk);
        check("idle_after_gap", 64'(busy), 64'd0);
    endtask

    // Memory model: accepts the request after a programmed delay, then returns 32 beats with optional gaps.
    initial begin
        int d;
        int g;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && !rst && dly_q.size() > 0) begin
                d = dly_q.pop_front();
                g = gap_q.pop_front();
                repeat (d) @(negedge clk);
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                for (int k = 0; k < BEATS && !rsp_abort; k++) begin
                    if ((g == 1 && k % 2 == 1) || (g == 2 && $urandom_range(0, 3) == 0)) begin
                        mem_rsp_valid = 1'b0;
                        @(negedge clk);
                    end
                    if (rsp_abort) break;
                    cur_beat      = k;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = beat_q.pop_front();
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b0;
                cur_beat      = -1;
            end
        end
    end

    // Monitor: compares every handshake, fill and resolved pulse against the scoreboard.
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    bit          pf = 1'b0;
    logic [31:0] pa = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 1'b0;
                pf = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("req_valid_held", 64'(mem_req_valid), 64'd1);
                    check("req_addr_stable", 64'(mem_req_addr), 64'(pa));
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (req_q.size() == 0) fail_msg($sformatf("spurious_req: addr %08h with no miss outstanding", mem_req_addr));
                    else check("mem_req_addr", 64'(mem_req_addr), 64'(req_q.pop_front()));
                end
                if (fill_valid) begin
                    if (exp_line_q.size() == 0) begin
                        fail_msg($sformatf("unexpected_fill: addr %08h with no line expected", fill_addr));
                    end else begin
                        check("fill_addr", 64'(fill_addr), 64'(fa_q.pop_front()));
                        check_line("fill_data", fill_data, exp_line_q.pop_front());
                        check("fill_wmask_all_ones", 64'(&fill_wmask), 64'd1);
                    end
                end
                if (repair_resolved || pf) check("resolved_after_fill", 64'(repair_resolved), 64'(pf));
                pv = mem_req_valid;
                pr = mem_req_ready;
                pa = mem_req_addr;
                pf = fill_valid;
            end
        end
    end

    initial begin
        bit found;
        rst                  = 1'b1;
        read_repair_request  = 1'b0;
        write_repair_request = 1'b0;
        missed_addr          = 32'h0000_0040;

        // Reset held with a read request pending: everything quiet, then a request the cycle after release.
        prep_txn(32'h0000_0040, 0, 0, 1'b0);
        read_repair_request = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_busy", 64'(busy), 64'd0);
            check("reset_req_valid", 64'(mem_req_valid), 64'd0);
            check("reset_req_addr", 64'(mem_req_addr), 64'd0);
            check("reset_fill_valid", 64'(fill_valid), 64'd0);
            check("reset_resolved", 64'(repair_resolved), 64'd0);
            check("reset_fill_addr", 64'(fill_addr), 64'd0);
            check("reset_wmask", 64'(|fill_wmask), 64'd0);
            check_line("reset_fill_data", fill_data, '0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("req_valid_after_reset", 64'(mem_req_valid), 64'd1);
        wait_resolved(lat);
        read_repair_request = 1'b0;
        repeat (2) @(negedge clk);

        // Directed read miss with ramp data and a fully back-to-back memory.
        run_txn(32'hAABB_CCDD, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, lat);
        check("min_latency", 64'(lat), 64'd36);
`ifdef DCACHE_REFILL_CWF_EN
        check("cwf_slot23_first_beat", 64'(fill_data[23*32 +: 32]), 64'd0);
        check("cwf_slot0_beat9", 64'(fill_data[31:0]), 64'h0909_0909);
`else
        check("slot0_beat0", 64'(fill_data[31:0]), 64'd0);
        check("slot31_beat31", 64'(fill_data[1023:992]), 64'h1F1F_1F1F);
`endif
        check("fill_addr_held", 64'(fill_addr), 64'hAABB_CC80);

        // Write miss with a slow request handshake and a beat gap every other beat.
        run_txn(32'h0000_0001, 1'b0, 1'b1, 4, 1, 1'b0, 1'b0, lat);

        // Both requests together, held through GAP: one burst only.
        run_txn(32'h0000_3F04, 1'b1, 1'b1, 1, 0, 1'b0, 1'b1, lat);

        // Reset during beat 10 aborts the burst without a fill.
        prep_txn(32'h0000_2000, 0, 0, 1'b0);
        @(negedge clk);
        missed_addr         = 32'h0000_2000;
        read_repair_request = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (cur_beat == 10) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_msg("abort_timeout: beat 10 never presented");
        rst                 = 1'b1;
        rsp_abort           = 1'b1;
        read_repair_request = 1'b0;
        repeat (2) @(negedge clk);
        beat_q.delete();
        exp_line_q.delete();
        fa_q.delete();
        req_q.delete();
        dly_q.delete();
        gap_q.delete();
        rsp_abort = 1'b0;
        rst       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_fill", 64'(fill_valid), 64'd0);
            check("abort_no_resolved", 64'(repair_resolved), 64'd0);
            check("abort_idle", 64'(busy), 64'd0);
        end
        run_txn(32'h0000_1000, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0, lat);

        // Randomised misses.
        for (int t = 0; t < 16; t++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_txn($urandom, sel[0], sel[1], $urandom_range(0, 3), $urandom_range(0, 2),
                    1'b0, 1'($urandom_range(0, 1)), lat);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_line_q.size() + req_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
